// File: rtl/hazard_pkg.sv
// Shared grid geometry, coordinate width and FSM encoding for the hazard
// bitmap encoder/decoder pair.
package hazard_pkg;

   localparam int GRID_ROWS  = 4;
   localparam int GRID_COLS  = 8;
   localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;
   localparam int COORD_W    = 11;
   localparam int ROW_W      = 2;
   localparam int COL_W      = 3;
   localparam int CELL_IDX_W = 5;
   localparam int CNT_W      = 5;

   localparam logic [COL_W-1:0]      COL_LAST = COL_W'(GRID_COLS - 1);
   localparam logic [CELL_IDX_W-1:0] IDX_LAST = CELL_IDX_W'(GRID_CELLS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] top;
      logic [COORD_W-1:0] left;
      logic [COORD_W-1:0] bottom;
      logic [COORD_W-1:0] right;
   } box_t;

   // True when any cell strictly after idx (row-major) is set.
   function automatic logic any_set_after(input logic [GRID_CELLS-1:0] map,
                                          input logic [CELL_IDX_W-1:0] idx);
      logic [GRID_CELLS-1:0] tail;
      tail = map >> ({1'b0, idx} + 6'd1);
      return |tail;
   endfunction

endpackage

// File: rtl/hazard_cell_to_box.sv
// Converts a horizontal run of grid cells into an inclusive pixel box.
module hazard_cell_to_box
   import hazard_pkg::*;
#(
   parameter int CELL_W = 8,
   parameter int CELL_H = 8
) (
   input  logic [ROW_W-1:0]   row,
   input  logic [COL_W-1:0]   col_start,
   input  logic [COL_W-1:0]   col_end,
   output logic [COORD_W-1:0] top,
   output logic [COORD_W-1:0] left,
   output logic [COORD_W-1:0] bottom,
   output logic [COORD_W-1:0] right
);

   localparam logic [COORD_W-1:0] CW  = COORD_W'(CELL_W);
   localparam logic [COORD_W-1:0] CH  = COORD_W'(CELL_H);
   localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

   logic [COORD_W-1:0] row_w;
   logic [COORD_W-1:0] c0_w;
   logic [COORD_W-1:0] c1_w;

   assign row_w = COORD_W'(row);
   assign c0_w  = COORD_W'(col_start);
   assign c1_w  = COORD_W'(col_end);

   assign top    = row_w * CH;
   assign bottom = (row_w + ONE) * CH - ONE;
   assign left   = c0_w * CW;
   assign right  = (c1_w + ONE) * CW - ONE;

endmodule

// File: rtl/hazard_decoder.sv
// Scans a 4x8 occupancy bitmap one cell per cycle and streams one pixel box
// per maximal horizontal run over a valid/ready interface.
module hazard_decoder
   import hazard_pkg::*;
#(
   parameter int CELL_W = 8,
   parameter int CELL_H = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           vec1,
   input  logic [15:0]           vec2,
   output logic                  busy,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [COORD_W-1:0]    out_top,
   output logic [COORD_W-1:0]    out_left,
   output logic [COORD_W-1:0]    out_bottom,
   output logic [COORD_W-1:0]    out_right,
   output logic                  out_last,
   output logic                  done,
   output logic [CNT_W-1:0]      num_hazards
);

   state_t                  state;
   state_t                  state_nxt;

   logic [GRID_CELLS-1:0]   map_q;
   logic [CELL_IDX_W:0]     cell_cnt;
   logic [CELL_IDX_W-1:0]   scan_idx;
   logic [ROW_W-1:0]        scan_row;
   logic [COL_W-1:0]        scan_col;
   logic                    scan_bit;
   logic                    scan_finished;

   logic                    run_open;
   logic [COL_W-1:0]        run_start;
   logic                    close_run;
   logic [COL_W-1:0]        seg_start;
   logic [COL_W-1:0]        seg_end;

   logic [CNT_W-1:0]        beat_cnt;
   logic                    last_q;
   box_t                    box_d;
   box_t                    box_q;

   assign scan_idx      = cell_cnt[CELL_IDX_W-1:0];
   assign scan_row      = scan_idx[CELL_IDX_W-1:COL_W];
   assign scan_col      = scan_idx[COL_W-1:0];
   assign scan_bit      = map_q[scan_idx];
   assign scan_finished = cell_cnt[CELL_IDX_W];

   // A run closes on the first clear cell after it, or on column 7 itself.
   assign close_run = (run_open || scan_bit) && (!scan_bit || scan_col == COL_LAST);
   assign seg_start = run_open ? run_start : scan_col;
   assign seg_end   = scan_bit ? scan_col : scan_col - COL_W'(1);

   hazard_cell_to_box #(
      .CELL_W (CELL_W),
      .CELL_H (CELL_H)
   ) u_cell_to_box (
      .row       (scan_row),
      .col_start (seg_start),
      .col_end   (seg_end),
      .top       (box_d.top),
      .left      (box_d.left),
      .bottom    (box_d.bottom),
      .right     (box_d.right)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: state_nxt gets a default first so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_SCAN;
         ST_SCAN: begin
            if (close_run)                  state_nxt = ST_EMIT;
            else if (scan_idx == IDX_LAST)  state_nxt = ST_DONE;
         end
         ST_EMIT: begin
            if (out_ready) state_nxt = scan_finished ? ST_DONE : ST_SCAN;
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != ST_IDLE);
      out_valid = (state == ST_EMIT);
      out_last  = (state == ST_EMIT) && last_q;
      done      = (state == ST_DONE);
   end

   // NOTE: the captured bitmap is cleared on reset along with the control
   // registers, so a post-reset decode never sees a stale map.
   always_ff @(posedge clk) begin
      if (rst) begin
         map_q       <= '0;
         cell_cnt    <= '0;
         run_open    <= 1'b0;
         run_start   <= '0;
         beat_cnt    <= '0;
         last_q      <= 1'b0;
         box_q       <= '0;
         num_hazards <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  map_q    <= {vec2, vec1};
                  cell_cnt <= '0;
                  run_open <= 1'b0;
                  beat_cnt <= '0;
               end
            end
            ST_SCAN: begin
               cell_cnt <= cell_cnt + 1'b1;
               if (close_run) begin
                  run_open <= 1'b0;
                  box_q    <= box_d;
                  last_q   <= !any_set_after(map_q, scan_idx);
               end else if (scan_bit && !run_open) begin
                  run_open  <= 1'b1;
                  run_start <= scan_col;
               end
            end
            ST_EMIT: begin
               if (out_ready) beat_cnt <= beat_cnt + 1'b1;
            end
            ST_DONE: num_hazards <= beat_cnt;
            default: ;
         endcase
      end
   end

   assign out_top    = box_q.top;
   assign out_left   = box_q.left;
   assign out_bottom = box_q.bottom;
   assign out_right  = box_q.right;

endmodule

// File: tb/tb_hazard_decoder.sv
// Scoreboard bench for hazard_decoder: directed bitmaps push expected beats,
// an independent monitor pops and compares on every accepted beat.
module tb_hazard_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] vec1;
   logic [15:0] vec2;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] out_top;
   logic [10:0] out_left;
   logic [10:0] out_bottom;
   logic [10:0] out_right;
   logic        out_last;
   logic        done;
   logic [4:0]  num_hazards;

   typedef struct packed {
      logic [10:0] top;
      logic [10:0] left;
      logic [10:0] bottom;
      logic [10:0] right;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    tests_run    = 0;
   int    tests_failed = 0;
   bit    ready_mode   = 1'b0;
   logic  ready_level  = 1'b1;
   bit    hold_pending = 1'b0;
   beat_t held;

   hazard_decoder #(
      .CELL_W (8),
      .CELL_H (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .vec1        (vec1),
      .vec2        (vec2),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_top     (out_top),
      .out_left    (out_left),
      .out_bottom  (out_bottom),
      .out_right   (out_right),
      .out_last    (out_last),
      .done        (done),
      .num_hazards (num_hazards)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests_run++;
      if (act !== expv) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   function automatic beat_t mk(input int r, input int c0, input int c1, input bit last);
      beat_t b;
      b.top    = 11'(r * 8);
      b.left   = 11'(c0 * 8);
      b.bottom = 11'(r * 8 + 7);
      b.right  = 11'(c1 * 8 + 7);
      b.last   = last;
      return b;
   endfunction

   // Sole driver of out_ready: either a held level or random stalls.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = ready_mode ? ($urandom_range(0, 2) != 0) : ready_level;
      end
   end

   // Monitor: checks stall stability and pops the scoreboard on each handshake.
   initial begin
      beat_t cur;
      beat_t want;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_pending = 1'b0;
         end else begin
            cur = {out_top, out_left, out_bottom, out_right, out_last};
            if (hold_pending) begin
               check("stall_valid", 64'(out_valid), 64'd1);
               check("stall_fields", 64'(cur), 64'(held));
            end
            hold_pending = 1'b0;
            if (out_valid) begin
               if (out_ready) begin
                  if (sb.size() == 0) begin
                     tests_run++;
                     tests_failed++;
                     $display("FAIL unexpected_beat: got 0x%0h, expected no beat", cur);
                  end else begin
                     want = sb.pop_front();
                     check("beat", 64'(cur), 64'(want));
                  end
               end else begin
                  hold_pending = 1'b1;
                  held         = cur;
               end
            end
         end
      end
   end

   task automatic run_map(input logic [15:0] v1, input logic [15:0] v2,
                          input int exp_n, input int exp_lat, input bit poke_busy);
      bit seen;
      int cyc;
      @(posedge clk);
      #1;
      vec1  = v1;
      vec2  = v2;
      start = 1'b1;
      seen  = 1'b0;
      cyc   = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i == 1) check("busy_in_scan", 64'(busy), 64'd1);
         if (done) begin
            seen = 1'b1;
            cyc  = i;
            break;
         end
         @(posedge clk);
         #1;
         start = poke_busy && (i == 4);
         if (poke_busy && i == 4) begin
            vec1 = 16'hFFFF;
            vec2 = 16'hFFFF;
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      if (seen && exp_lat >= 0) check("done_latency", 64'(cyc), 64'(exp_lat));
      start = 1'b0;
      @(negedge clk);
      check("num_hazards", 64'(num_hazards), 64'(exp_n));
      check("busy_after", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      bit saw;
      rst   = 1'b1;
      start = 1'b0;
      vec1  = '0;
      vec2  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_last", 64'(out_last), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_num", 64'(num_hazards), 64'd0);
      check("rst_box", 64'({out_top, out_left, out_bottom, out_right}), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single cell at r0c0.
      sb.push_back(mk(0, 0, 0, 1'b1));
      run_map(16'h0001, 16'h0000, 1, 34, 1'b0);

      // Run at r3c6..c7 closes on the final cell.
      sb.push_back(mk(3, 6, 7, 1'b1));
      run_map(16'h0000, 16'hC000, 1, 34, 1'b0);

      // Full map: one box per row, never merged across rows.
      for (int r = 0; r < 4; r++) sb.push_back(mk(r, 0, 7, r == 3));
      run_map(16'hFFFF, 16'hFFFF, 4, 37, 1'b0);

      // Checkerboard columns with random backpressure.
      ready_mode = 1'b1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c += 2)
            sb.push_back(mk(r, c, c, (r == 3) && (c == 6)));
      run_map(16'h5555, 16'h5555, 16, -1, 1'b0);
      ready_mode = 1'b0;

      // Empty map, with a second start poked while busy.
      run_map(16'h0000, 16'h0000, 0, 33, 1'b1);

      // Reset during a stalled beat aborts the decode.
      @(posedge clk);
      #1;
      ready_level = 1'b0;
      vec1  = 16'h0001;
      vec2  = 16'h0000;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      saw   = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid) begin
            saw = 1'b1;
            break;
         end
      end
      check("stall_valid_seen", 64'(saw), 64'd1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("abort_valid", 64'(out_valid), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_num", 64'(num_hazards), 64'd0);
      @(posedge clk);
      #1;
      rst         = 1'b0;
      ready_level = 1'b1;
      saw         = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || out_valid) saw = 1'b1;
      end
      check("no_activity_after_abort", 64'(saw), 64'd0);

      // Fresh decode after the abort.
      sb.push_back(mk(0, 0, 0, 1'b1));
      run_map(16'h0001, 16'h0000, 1, 34, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_decoder.md
HAZARD_DECODER -- requirements
Module: hazard_decoder

Interface
REQ-001 SHALL have parameter CELL_W, default 8, meaning grid cell width in pixels.
REQ-002 SHALL have parameter CELL_H, default 8, meaning grid cell height in pixels.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to decode the presented bitmap.
REQ-006 SHALL have port vec1  input  16  occupancy of grid rows 0-1; bit r*8+c = cell (r,c).
REQ-007 SHALL have port vec2  input  16  occupancy of grid rows 2-3; bit (r-2)*8+c = cell (r,c).
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port out_valid  output  1  box beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-011 SHALL have ports out_top, out_left, out_bottom, out_right  output  11 each  inclusive pixel box.
REQ-012 SHALL have port out_last  output  1  qualifies final box of the map.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of decode.
REQ-014 SHALL have port num_hazards  output  5  boxes emitted in last decode (0-16).

Function
REQ-015 Grid SHALL be 4 rows x 8 columns, 32 cells; bitmap captured into a register on accepted start.
REQ-016 start SHALL be accepted only in IDLE; start while busy is ignored, captured map unchanged.
REQ-017 FSM states SHALL be IDLE, SCAN, EMIT, DONE.
REQ-018 IDLE->SCAN on start; SCAN visits one cell per cycle in row-major order (r0c0 first, r3c7 last).
REQ-019 Each maximal horizontal run of set cells within one row SHALL produce exactly one box; runs never merge across rows.
REQ-020 A run SHALL close on the first clear cell after it or at column 7; the closing cell is consumed; SCAN->EMIT.
REQ-021 Box SHALL be top=r*CELL_H, bottom=(r+1)*CELL_H-1, left=c0*CELL_W, right=(c1+1)*CELL_W-1, computed in 11 bits (no overflow at defaults).
REQ-022 In EMIT, out_valid SHALL be high with stable box fields until out_valid&&out_ready; then EMIT->SCAN at the next cell, or ->DONE if cell r3c7 was consumed.
REQ-023 out_valid SHALL NOT drop, and fields SHALL NOT change, while out_ready is low.
REQ-024 out_last SHALL be high on a beat iff no set cell exists after the run's closing cell.
REQ-025 SCAN after consuming r3c7 with no open run SHALL go to DONE.
REQ-026 DONE SHALL pulse done for one cycle, update num_hazards to the beat count, and return to IDLE; start is accepted in IDLE on the following cycle.
REQ-027 Empty map SHALL produce no beats, done at cycle 33 after start cycle, num_hazards=0.
REQ-028 With out_ready held high, a box for a run closing at cell k SHALL appear valid the cycle after cell k is scanned; each beat adds one cycle.
REQ-029 busy SHALL be high in SCAN, EMIT and DONE.

Reset
REQ-030 rst SHALL force IDLE, busy=0, out_valid=0, out_last=0, done=0, num_hazards=0, box fields=0, counters and captured map cleared.
REQ-031 rst mid-SCAN or mid-EMIT SHALL abort decode; a pending beat is discarded; no done pulse.

Structure
REQ-032 Grid dimensions (4, 8), coordinate width (11), and FSM state encoding SHALL live in a shared hazard package used by encoder and decoder.
REQ-033 Box arithmetic SHALL be a sub-module hazard_cell_to_box (row, col_start, col_end -> four coordinates).

Verification
REQ-034 vec1=16'h0001, vec2=0, ready=1 -> one beat (0,0,7,7), last=1, num_hazards=1.
REQ-035 vec1=0, vec2=16'hC000 -> one beat top=24,left=48,bottom=31,right=63, last=1.
REQ-036 vec1=vec2=16'hFFFF -> four beats, full rows, left=0,right=63, top=0/8/16/24; last on fourth only; num_hazards=4.
REQ-037 vec1=vec2=16'h5555, random out_ready stalls -> 16 one-cell beats in row-major order, fields stable during stalls, num_hazards=16.
REQ-038 Empty map -> no out_valid, done 33 cycles after start, num_hazards=0; second start during busy ignored.
REQ-039 rst asserted while out_valid=1 and out_ready=0 -> next cycle IDLE, out_valid=0, no done; fresh start decodes correctly.
